// File: rtl/pipe_pkg.sv
// Shared pipeline definitions: forwarding source encoding and the
// register-index match helper used by the operand stage.
package pipe_pkg;

  localparam int REG_ADDR_W = 5;

  typedef enum logic [1:0] {
    FWD_RF,
    FWD_WB,
    FWD_MEM,
    FWD_EX
  } fwd_src_e;

  // A producer matches a source when it writes, the source is used and the indices agree.
  function automatic logic hit(
    input logic                  we,
    input logic [REG_ADDR_W-1:0] rd,
    input logic [REG_ADDR_W-1:0] rs,
    input logic                  en
  );
    return we & en & (rd == rs);
  endfunction

endpackage

// File: rtl/id_ex_operand_stage_if.sv
// Signal bundle between decode/regfile/forwarding sources and the ID->EX
// operand stage. master drives the decode side, slave is the stage itself.
interface id_ex_operand_stage_if #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5,
  parameter int CNT_W  = 16
);

  logic              id_valid;
  logic [ADDR_W-1:0] id_rs1;
  logic [ADDR_W-1:0] id_rs2;
  logic [ADDR_W-1:0] id_rss;
  logic              id_rs1_en;
  logic              id_rs2_en;
  logic              id_rss_en;
  logic [ADDR_W-1:0] id_rd;
  logic              id_rd_we;
  logic              id_is_load;

  logic [ADDR_W-1:0] rf_raddr1;
  logic [ADDR_W-1:0] rf_raddr2;
  logic [ADDR_W-1:0] rf_swaddr;
  logic              rf_read1;
  logic              rf_read2;
  logic              rf_swread;
  logic [DATA_W-1:0] rf_dout1;
  logic [DATA_W-1:0] rf_dout2;
  logic [DATA_W-1:0] rf_swdout;

  logic              fwd_ex_we;
  logic [ADDR_W-1:0] fwd_ex_rd;
  logic [DATA_W-1:0] fwd_ex_data;
  logic              fwd_ex_load;
  logic              fwd_mem_we;
  logic [ADDR_W-1:0] fwd_mem_rd;
  logic [DATA_W-1:0] fwd_mem_data;
  logic              fwd_wb_we;
  logic [ADDR_W-1:0] fwd_wb_rd;
  logic [DATA_W-1:0] fwd_wb_data;

  logic              ex_stall;
  logic              flush;
  logic              id_stall;

  logic              ex_valid;
  logic [DATA_W-1:0] ex_op1;
  logic [DATA_W-1:0] ex_op2;
  logic [DATA_W-1:0] ex_sdata;
  logic [ADDR_W-1:0] ex_rd;
  logic              ex_rd_we;
  logic              ex_is_load;
  logic [CNT_W-1:0]  stall_cnt;

  modport master (
    output id_valid, id_rs1, id_rs2, id_rss, id_rs1_en, id_rs2_en, id_rss_en,
    output id_rd, id_rd_we, id_is_load,
    input  rf_raddr1, rf_raddr2, rf_swaddr, rf_read1, rf_read2, rf_swread,
    output rf_dout1, rf_dout2, rf_swdout,
    output fwd_ex_we, fwd_ex_rd, fwd_ex_data, fwd_ex_load,
    output fwd_mem_we, fwd_mem_rd, fwd_mem_data,
    output fwd_wb_we, fwd_wb_rd, fwd_wb_data,
    output ex_stall, flush,
    input  id_stall,
    input  ex_valid, ex_op1, ex_op2, ex_sdata, ex_rd, ex_rd_we, ex_is_load, stall_cnt
  );

  modport slave (
    input  id_valid, id_rs1, id_rs2, id_rss, id_rs1_en, id_rs2_en, id_rss_en,
    input  id_rd, id_rd_we, id_is_load,
    output rf_raddr1, rf_raddr2, rf_swaddr, rf_read1, rf_read2, rf_swread,
    input  rf_dout1, rf_dout2, rf_swdout,
    input  fwd_ex_we, fwd_ex_rd, fwd_ex_data, fwd_ex_load,
    input  fwd_mem_we, fwd_mem_rd, fwd_mem_data,
    input  fwd_wb_we, fwd_wb_rd, fwd_wb_data,
    input  ex_stall, flush,
    output id_stall,
    output ex_valid, ex_op1, ex_op2, ex_sdata, ex_rd, ex_rd_we, ex_is_load, stall_cnt
  );

endinterface

// File: rtl/operand_fwd_mux.sv
// One operand's bypass network: picks the youngest in-flight producer of the
// source register, falling back to regfile data; unused sources read as 0.
module operand_fwd_mux
  import pipe_pkg::*;
#(
  parameter int DATA_W = 32
) (
  input  logic                  src_en,
  input  logic [REG_ADDR_W-1:0] src_idx,
  input  logic [DATA_W-1:0]     rf_data,
  input  logic                  ex_we,
  input  logic                  ex_load,
  input  logic [REG_ADDR_W-1:0] ex_rd,
  input  logic [DATA_W-1:0]     ex_data,
  input  logic                  mem_we,
  input  logic [REG_ADDR_W-1:0] mem_rd,
  input  logic [DATA_W-1:0]     mem_data,
  input  logic                  wb_we,
  input  logic [REG_ADDR_W-1:0] wb_rd,
  input  logic [DATA_W-1:0]     wb_data,
  output logic [DATA_W-1:0]     operand
);

  fwd_src_e sel;

  // Priority select EX > MEM > WB > regfile; an EX load has no data yet so it never bypasses.
  always_comb begin
    sel = FWD_RF;
    if (hit(ex_we & ~ex_load, ex_rd, src_idx, src_en)) begin
      sel = FWD_EX;
    end else if (hit(mem_we, mem_rd, src_idx, src_en)) begin
      sel = FWD_MEM;
    end else if (hit(wb_we, wb_rd, src_idx, src_en)) begin
      sel = FWD_WB;
    end
  end

  // Data mux; a disabled source is forced to zero regardless of any match.
  always_comb begin
    operand = rf_data;
    case (sel)
      FWD_EX:  operand = ex_data;
      FWD_MEM: operand = mem_data;
      FWD_WB:  operand = wb_data;
      default: operand = rf_data;
    endcase
    if (!src_en) begin
      operand = '0;
    end
  end

endmodule

// File: rtl/id_ex_operand_stage.sv
// ID->EX operand stage: drives regfile reads, bypasses in-flight results,
// inserts one bubble on load-use and registers the EX slot.
module id_ex_operand_stage
  import pipe_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int ADDR_W = REG_ADDR_W,
  parameter int CNT_W  = 16
) (
  input logic                  clk,
  input logic                  rst,
  id_ex_operand_stage_if.slave bus
);

  logic [DATA_W-1:0] op1_p0;
  logic [DATA_W-1:0] op2_p0;
  logic [DATA_W-1:0] sdata_p0;
  logic              src_hit_ex_p0;
  logic              load_use_p0;

  logic              vld_p1;
  logic [DATA_W-1:0] op1_p1;
  logic [DATA_W-1:0] op2_p1;
  logic [DATA_W-1:0] sdata_p1;
  logic [ADDR_W-1:0] rd_p1;
  logic              rd_we_p1;
  logic              is_load_p1;
  logic [CNT_W-1:0]  stall_cnt_p1;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (v == {CNT_W{1'b1}}) ? v : v + {{(CNT_W-1){1'b0}}, 1'b1};
  endfunction

  // ---- p0: regfile addressing, bypass and hazard detection ----
  assign bus.rf_raddr1 = bus.id_rs1;
  assign bus.rf_raddr2 = bus.id_rs2;
  assign bus.rf_swaddr = bus.id_rss;
  assign bus.rf_read1  = bus.id_valid & bus.id_rs1_en;
  assign bus.rf_read2  = bus.id_valid & bus.id_rs2_en;
  assign bus.rf_swread = bus.id_valid & bus.id_rss_en;

  operand_fwd_mux #(.DATA_W(DATA_W)) u_fwd_op1 (
    .src_en   (bus.id_rs1_en),
    .src_idx  (bus.id_rs1),
    .rf_data  (bus.rf_dout1),
    .ex_we    (bus.fwd_ex_we),
    .ex_load  (bus.fwd_ex_load),
    .ex_rd    (bus.fwd_ex_rd),
    .ex_data  (bus.fwd_ex_data),
    .mem_we   (bus.fwd_mem_we),
    .mem_rd   (bus.fwd_mem_rd),
    .mem_data (bus.fwd_mem_data),
    .wb_we    (bus.fwd_wb_we),
    .wb_rd    (bus.fwd_wb_rd),
    .wb_data  (bus.fwd_wb_data),
    .operand  (op1_p0)
  );

  operand_fwd_mux #(.DATA_W(DATA_W)) u_fwd_op2 (
    .src_en   (bus.id_rs2_en),
    .src_idx  (bus.id_rs2),
    .rf_data  (bus.rf_dout2),
    .ex_we    (bus.fwd_ex_we),
    .ex_load  (bus.fwd_ex_load),
    .ex_rd    (bus.fwd_ex_rd),
    .ex_data  (bus.fwd_ex_data),
    .mem_we   (bus.fwd_mem_we),
    .mem_rd   (bus.fwd_mem_rd),
    .mem_data (bus.fwd_mem_data),
    .wb_we    (bus.fwd_wb_we),
    .wb_rd    (bus.fwd_wb_rd),
    .wb_data  (bus.fwd_wb_data),
    .operand  (op2_p0)
  );

  operand_fwd_mux #(.DATA_W(DATA_W)) u_fwd_sdata (
    .src_en   (bus.id_rss_en),
    .src_idx  (bus.id_rss),
    .rf_data  (bus.rf_swdout),
    .ex_we    (bus.fwd_ex_we),
    .ex_load  (bus.fwd_ex_load),
    .ex_rd    (bus.fwd_ex_rd),
    .ex_data  (bus.fwd_ex_data),
    .mem_we   (bus.fwd_mem_we),
    .mem_rd   (bus.fwd_mem_rd),
    .mem_data (bus.fwd_mem_data),
    .wb_we    (bus.fwd_wb_we),
    .wb_rd    (bus.fwd_wb_rd),
    .wb_data  (bus.fwd_wb_data),
    .operand  (sdata_p0)
  );

  assign src_hit_ex_p0 = hit(bus.fwd_ex_we, bus.fwd_ex_rd, bus.id_rs1, bus.id_rs1_en)
                       | hit(bus.fwd_ex_we, bus.fwd_ex_rd, bus.id_rs2, bus.id_rs2_en)
                       | hit(bus.fwd_ex_we, bus.fwd_ex_rd, bus.id_rss, bus.id_rss_en);
  assign load_use_p0   = bus.id_valid & bus.fwd_ex_load & src_hit_ex_p0;
  assign bus.id_stall  = bus.ex_stall | load_use_p0;

  // ---- p1: EX slot register ----
  // Flush kills the slot, stall holds it, load-use bubbles it, otherwise decode advances.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vld_p1       <= 1'b0;
      op1_p1       <= '0;
      op2_p1       <= '0;
      sdata_p1     <= '0;
      rd_p1        <= '0;
      rd_we_p1     <= 1'b0;
      is_load_p1   <= 1'b0;
      stall_cnt_p1 <= '0;
    end else if (bus.flush) begin
      vld_p1     <= 1'b0;
      rd_we_p1   <= 1'b0;
      is_load_p1 <= 1'b0;
    end else if (!bus.ex_stall) begin
      if (load_use_p0) begin
        vld_p1       <= 1'b0;
        rd_we_p1     <= 1'b0;
        is_load_p1   <= 1'b0;
        stall_cnt_p1 <= sat_inc(stall_cnt_p1);
      end else begin
        vld_p1     <= bus.id_valid;
        op1_p1     <= op1_p0;
        op2_p1     <= op2_p0;
        sdata_p1   <= sdata_p0;
        rd_p1      <= bus.id_rd;
        rd_we_p1   <= bus.id_valid & bus.id_rd_we;
        is_load_p1 <= bus.id_valid & bus.id_is_load;
      end
    end
  end

  assign bus.ex_valid   = vld_p1;
  assign bus.ex_op1     = op1_p1;
  assign bus.ex_op2     = op2_p1;
  assign bus.ex_sdata   = sdata_p1;
  assign bus.ex_rd      = rd_p1;
  assign bus.ex_rd_we   = rd_we_p1;
  assign bus.ex_is_load = is_load_p1;
  assign bus.stall_cnt  = stall_cnt_p1;

endmodule
